// File: rtl/k12a_alu_pkg.sv
// Shared types and constants for the k12a byte-serial wide ALU sequencer.
//   alu_op_e     : operation select (ADD, SUB, ADC, SBC)
//   seq_state_e  : sequencer FSM states
//   alu_flags_t  : condition flag bundle, MSB first: zero..sle
package k12a_alu_pkg;

  localparam int unsigned ALU_BYTE_W = 8;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_ADC = 2'd2,
    ALU_SBC = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_BYTE = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic lsb;
    logic overflow;
    logic ult;
    logic ule;
    logic slt;
    logic sle;
  } alu_flags_t;

endpackage

// File: rtl/k12a_alu_wide_seq_if.sv
// Request/result bundle between the k12a control unit (master) and the
// wide-ALU sequencer (slave).
//   master drives : start, op, carry_in, operand_a, operand_b
//   slave drives  : busy, done, result, carry_out and the eight flags
interface k12a_alu_wide_seq_if
  import k12a_alu_pkg::*;
#(
  parameter int unsigned NBYTES = 2
) ();

  localparam int unsigned WORD_W = ALU_BYTE_W * NBYTES;

  logic              start;
  alu_op_e           op;
  logic              carry_in;
  logic [WORD_W-1:0] operand_a;
  logic [WORD_W-1:0] operand_b;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] result;
  logic              carry_out;
  logic              zero;
  logic              negative;
  logic              lsb;
  logic              overflow;
  logic              ult;
  logic              ule;
  logic              slt;
  logic              sle;

  modport master (
    output start, op, carry_in, operand_a, operand_b,
    input  busy, done, result, carry_out,
    input  zero, negative, lsb, overflow, ult, ule, slt, sle
  );

  modport slave (
    input  start, op, carry_in, operand_a, operand_b,
    output busy, done, result, carry_out,
    output zero, negative, lsb, overflow, ult, ule, slt, sle
  );

endinterface

// File: rtl/k12a_alu_flag_calc.sv
// Combinational k12a flag derivation for a completed wide add/subtract.
//   zero_acc : every result byte was zero
//   res_msb  : result sign bit
//   res_lsb  : result bit 0
//   a_msb    : top bit of the most significant adder input A byte
//   b_msb    : top bit of the most significant adder input B byte (post-invert)
//   carry    : final adder carry-out
//   flags_c  : derived flag set (parent registers it)
module k12a_alu_flag_calc
  import k12a_alu_pkg::*;
(
  input  logic       zero_acc,
  input  logic       res_msb,
  input  logic       res_lsb,
  input  logic       a_msb,
  input  logic       b_msb,
  input  logic       carry,
  output alu_flags_t flags_c
);

  always_comb begin
    flags_c          = '0;
    flags_c.zero     = zero_acc;
    flags_c.negative = res_msb;
    flags_c.lsb      = res_lsb;
    // Signed overflow: both adder inputs disagree in sign with the result.
    flags_c.overflow = (a_msb ^ res_msb) & (b_msb ^ res_msb);
    flags_c.ult      = ~carry;
    flags_c.ule      = ~carry | zero_acc;
    flags_c.slt      = res_msb ^ flags_c.overflow;
    flags_c.sle      = flags_c.slt | zero_acc;
  end

endmodule

// File: rtl/k12a_alu_wide_seq.sv
// Byte-serial wide add/subtract sequencer driving a shared 8-bit adder.
//   clock, reset            : clock and synchronous active-high reset
//   bus (slave)             : request operands/op, busy/done, result and flags
//   adder_a/adder_b/adder_cin : shared adder inputs, zero when not in BYTE
//   adder_sum/adder_cout    : shared adder combinational outputs
module k12a_alu_wide_seq
  import k12a_alu_pkg::*;
#(
  parameter int unsigned NBYTES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  k12a_alu_wide_seq_if.slave    bus,
  output logic [ALU_BYTE_W-1:0] adder_a,
  output logic [ALU_BYTE_W-1:0] adder_b,
  output logic                  adder_cin,
  input  logic [ALU_BYTE_W-1:0] adder_sum,
  input  logic                  adder_cout
);

  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef logic [NBYTES-1:0][ALU_BYTE_W-1:0] word_t;

  seq_state_e       state, state_next;
  word_t            a_q, b_q, result_q;
  alu_op_e          op_q;
  logic             cin_q;
  logic [IDX_W-1:0] idx;
  logic             carry_q;
  logic             zero_acc;
  logic             carry_out_q;
  logic             busy_q, done_q;
  alu_flags_t       flags_q, flags_c;
  logic             accept;
  logic             last_byte;

  assign accept    = bus.start && (state == SEQ_IDLE || state == SEQ_DONE);
  assign last_byte = (state == SEQ_BYTE) && (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= SEQ_IDLE;
    else       state <= state_next;
  end

  // Next state and adder drive.
  always_comb begin
    state_next = state;
    adder_a    = '0;
    adder_b    = '0;
    adder_cin  = 1'b0;
    case (state)
      SEQ_IDLE: if (bus.start) state_next = SEQ_BYTE;
      SEQ_BYTE: begin
        if (idx == LAST_IDX) state_next = SEQ_DONE;
        adder_a = a_q[idx];
        adder_b = (op_q == ALU_SUB || op_q == ALU_SBC) ? ~b_q[idx] : b_q[idx];
        if (idx == '0) begin
          case (op_q)
            ALU_ADD: adder_cin = 1'b0;
            ALU_SUB: adder_cin = 1'b1;
            default: adder_cin = cin_q;
          endcase
        end else begin
          adder_cin = carry_q;
        end
      end
      SEQ_DONE: state_next = bus.start ? SEQ_BYTE : SEQ_IDLE;
      default:  state_next = SEQ_IDLE;
    endcase
  end

  // Flags are taken from the live final byte so they land together with done.
  k12a_alu_flag_calc u_flag_calc (
    .zero_acc (zero_acc & (adder_sum == '0)),
    .res_msb  (adder_sum[ALU_BYTE_W-1]),
    .res_lsb  (result_q[0][0]),
    .a_msb    (adder_a[ALU_BYTE_W-1]),
    .b_msb    (adder_b[ALU_BYTE_W-1]),
    .carry    (adder_cout),
    .flags_c  (flags_c)
  );

  // Operand latch, byte accumulation and result/flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= ALU_ADD;
      cin_q       <= 1'b0;
      idx         <= '0;
      carry_q     <= 1'b0;
      zero_acc    <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      flags_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      busy_q <= (state_next == SEQ_BYTE);
      done_q <= (state_next == SEQ_DONE);
      if (accept) begin
        a_q      <= bus.operand_a;
        b_q      <= bus.operand_b;
        op_q     <= bus.op;
        cin_q    <= bus.carry_in;
        idx      <= '0;
        zero_acc <= 1'b1;
      end else if (state == SEQ_BYTE) begin
        result_q[idx] <= adder_sum;
        carry_q       <= adder_cout;
        zero_acc      <= zero_acc & (adder_sum == '0);
        idx           <= idx + IDX_W'(1);
        if (last_byte) begin
          carry_out_q <= adder_cout;
          flags_q     <= flags_c;
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.zero      = flags_q.zero;
  assign bus.negative  = flags_q.negative;
  assign bus.lsb       = flags_q.lsb;
  assign bus.overflow  = flags_q.overflow;
  assign bus.ult       = flags_q.ult;
  assign bus.ule       = flags_q.ule;
  assign bus.slt       = flags_q.slt;
  assign bus.sle       = flags_q.sle;

endmodule

// File: tb/tb_k12a_alu_wide_seq.sv
// Directed bench for k12a_alu_wide_seq with NBYTES=2 and a behavioural 8-bit adder.
module tb_k12a_alu_wide_seq;
  import k12a_alu_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] adder_a, adder_b, adder_sum;
  logic       adder_cin, adder_cout;

  int total = 0;
  int bad   = 0;

  k12a_alu_wide_seq_if #(.NBYTES(2)) bus ();

  k12a_alu_wide_seq #(.NBYTES(2)) dut (
    .clock      (clk),
    .reset      (reset),
    .bus        (bus),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout)
  );

  // Shared 8-bit adder seen by the sequencer.
  assign {adder_cout, adder_sum} = 9'(adder_a) + 9'(adder_b) + 9'(adder_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_op_e     op;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        cout;
    logic [7:0]  flg;   // zero,negative,lsb,overflow,ult,ule,slt,sle
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] get_flags();
    return {bus.zero, bus.negative, bus.lsb, bus.overflow,
            bus.ult, bus.ule, bus.slt, bus.sle};
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "/busy"},   32'(bus.busy),      32'd0);
    check({tag, "/done"},   32'(bus.done),      32'd0);
    check({tag, "/result"}, 32'(bus.result),    32'd0);
    check({tag, "/cout"},   32'(bus.carry_out), 32'd0);
    check({tag, "/flags"},  32'(get_flags()),   32'd0);
    check({tag, "/adder"},  32'({adder_a, adder_b, adder_cin}), 32'd0);
  endtask

  // Issue at the current (negedge) time, then scramble inputs after accept.
  task automatic run_op(input vec_t v);
    bus.op        = v.op;
    bus.carry_in  = v.cin;
    bus.operand_a = v.a;
    bus.operand_b = v.b;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.operand_a = ~v.a;
    bus.operand_b = ~v.b;
    bus.carry_in  = ~v.cin;
    bus.op        = alu_op_e'(v.op ^ 2'd1);
    @(negedge clk);
    check({v.name, "/c1_busy"}, 32'(bus.busy), 32'd1);
    check({v.name, "/c1_done"}, 32'(bus.done), 32'd0);
    @(negedge clk);
    check({v.name, "/c2_busy"}, 32'(bus.busy), 32'd1);
    check({v.name, "/c2_done"}, 32'(bus.done), 32'd0);
    @(negedge clk);
    check({v.name, "/c3_done"}, 32'(bus.done), 32'd1);
    check({v.name, "/c3_busy"}, 32'(bus.busy), 32'd0);
    check({v.name, "/result"},  32'(bus.result), 32'(v.res));
    check({v.name, "/cout"},    32'(bus.carry_out), 32'(v.cout));
    check({v.name, "/flags"},   32'(get_flags()), 32'(v.flg));
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{ALU_ADD, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 8'b0000_1100, "add_ff_1"};
    vecs[1] = '{ALU_SUB, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b1, 8'b1000_0101, "sub_equal"};
    vecs[2] = '{ALU_SUB, 1'b0, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 8'b0110_1111, "sub_neg"};
    vecs[3] = '{ALU_SUB, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 8'b0011_0011, "sub_ovf"};
    vecs[4] = '{ALU_ADC, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 8'b1000_0101, "adc_wrap"};
    vecs[5] = '{ALU_ADD, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 8'b0101_1100, "add_ovf"};
    vecs[6] = '{ALU_SBC, 1'b0, 16'h0005, 16'h0003, 16'h0001, 1'b1, 8'b0010_0000, "sbc_borrow"};
    vecs[7] = '{ALU_ADC, 1'b0, 16'h1000, 16'h2000, 16'h3000, 1'b0, 8'b0000_1100, "adc_nocarry"};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op        = ALU_ADD;
    bus.carry_in  = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;

    // Odd entries are followed by an idle gap; even entries chain straight
    // into the next op with start asserted during DONE.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i]);
      if (i % 2 == 1) begin
        @(negedge clk);
        check({vecs[i].name, "/idle_done"},   32'(bus.done),   32'd0);
        check({vecs[i].name, "/idle_busy"},   32'(bus.busy),   32'd0);
        check({vecs[i].name, "/idle_hold"},   32'(bus.result), 32'(vecs[i].res));
        check({vecs[i].name, "/idle_adder"},  32'({adder_a, adder_b, adder_cin}), 32'd0);
      end
    end

    // Start pulsed during BYTE must be ignored and not queued.
    v = '{ALU_ADD, 1'b0, 16'h0102, 16'h0304, 16'h0406, 1'b0, 8'b0000_1100, "ignore"};
    bus.op = v.op; bus.carry_in = v.cin; bus.operand_a = v.a; bus.operand_b = v.b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.operand_a = 16'hFFFF;
    bus.op = ALU_SUB;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("ignore/c2_busy", 32'(bus.busy), 32'd1);
    check("ignore/c2_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("ignore/c3_done",  32'(bus.done),   32'd1);
    check("ignore/result",   32'(bus.result), 32'(v.res));
    check("ignore/flags",    32'(get_flags()), 32'(v.flg));
    @(negedge clk);
    check("ignore/c4_done", 32'(bus.done), 32'd0);
    check("ignore/c4_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("ignore/c5_done", 32'(bus.done), 32'd0);

    // Reset at byte 1 aborts the operation with no done.
    bus.op = ALU_SUB; bus.operand_a = 16'h0001; bus.operand_b = 16'h0002;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("abort/c1_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("abort/c2_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_cleared("abort");
    reset = 1'b0;
    @(negedge clk);
    check("abort/no_done", 32'(bus.done), 32'd0);
    check("abort/no_busy", 32'(bus.busy), 32'd0);

    // Reset and start together: reset wins.
    reset = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_start/busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("rst_start/busy2", 32'(bus.busy), 32'd0);
    check("rst_start/done",  32'(bus.done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/k12a_alu_wide_seq.md
# k12a_alu_wide_seq

Multi-cycle sequencer that runs the single 8-bit ALU adder byte-serially to perform NBYTES-wide add/subtract with carry chaining. It produces a full-width result plus the standard k12a condition flags (zero, negative, lsb, overflow, ult, ule, slt, sle) evaluated over the whole word. It sits between the k12a control unit and the shared adder: it owns the adder's inputs while busy and releases them when idle.

## Interface

Parameters:
- NBYTES, 2: operand width in bytes; legal values are ≥ 2.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; accepted only in IDLE or DONE.
- op  in  2  operation: ADD=0, SUB=1, ADC=2, SBC=3.
- carry_in  in  1  carry for ADC/SBC; a borrow is encoded as carry_in=0.
- operand_a  in  8*NBYTES  first operand; sampled at accept.
- operand_b  in  8*NBYTES  second operand; sampled at accept.
- busy  out  1  high in BYTE state.
- done  out  1  high for exactly one cycle in DONE.
- result  out  8*NBYTES  full-width sum or difference; held until the next accept.
- carry_out  out  1  final adder carry.
- zero, negative, lsb, overflow, ult, ule, slt, sle  out  1 each  flags; held with result.
- adder_a  out  8  adder input 1.
- adder_b  out  8  adder input 2 (already inverted for SUB/SBC).
- adder_cin  out  1  adder carry-in.
- adder_sum  in  8  adder output; combinational.
- adder_cout  in  1  adder carry-out; combinational.

## Operation

- FSM states: IDLE, BYTE, DONE.
  - IDLE→BYTE on start.
  - BYTE stays in BYTE while idx < NBYTES-1, then goes to DONE.
  - DONE→BYTE if start is high, otherwise DONE→IDLE.
- On accept:
  - Latch operand_a, operand_b, op and carry_in.
  - Set idx=0.
  - Set the zero accumulator to 1.
- In BYTE, byte index idx:
  - adder_a = a[idx].
  - adder_b = b[idx] for ADD/ADC, ~b[idx] for SUB/SBC.
  - adder_cin at idx=0: ADD→0, SUB→1, ADC/SBC→latched carry_in.
  - adder_cin at idx>0: the registered carry from the previous byte.
  - At the clock edge: result[idx] ← adder_sum, carry_reg ← adder_cout, zero_acc ← zero_acc & (adder_sum==0), idx ← idx+1.
  - When idx = NBYTES-1, also register a_msb = adder_a[7] and b_msb = adder_b[7].
- Flags, registered on entry to DONE:
  - zero = zero_acc, over the full result.
  - negative = result MSB.
  - lsb = result[0].
  - overflow = (a_msb ^ negative) & (b_msb ^ negative).
  - ult = ~carry_out.
  - ule = ult | zero.
  - slt = negative ^ overflow.
  - sle = slt | zero.
- adder_a, adder_b and adder_cin are driven 0 outside BYTE.
- A start asserted while busy is ignored and not queued.
- Operands may change after accept without affecting the operation in flight.

## Timing

- Reset values: state=IDLE, busy=0, done=0, result=0, carry_out=0, all flags=0, adder outputs=0.
- Accept at edge t → busy high for cycles t+1 … t+NBYTES → done high in cycle t+NBYTES+1.
- Latency: NBYTES+1 cycles from accept to done.
- result and flags become valid with done and stay stable until the edge after the next accept.
- Back-to-back: a start during DONE is accepted, so done is never high two consecutive cycles. Throughput is one operation per NBYTES+1 cycles.
- Reset asserted mid-BYTE: the next state is IDLE, all outputs return to reset values and no done is issued.
- Reset and start in the same cycle: reset wins.
- The adder path is combinational within one cycle. No registered adder output is assumed.

## Structure

- k12a_alu_pkg holds:
  - the op enum (ALU_ADD, ALU_SUB, ALU_ADC, ALU_SBC);
  - the state enum (SEQ_IDLE, SEQ_BYTE, SEQ_DONE);
  - the ALU_BYTE_W=8 constant.
- One sub-module, k12a_alu_flag_calc: combinational derivation of the flag set from zero_acc, result MSB, result[0], a_msb, b_msb and the final carry. Its outputs are registered by the parent.
- The byte index counter is $clog2(NBYTES) bits wide.

## Test plan

All scenarios use NBYTES=2.
1. ADD 0x00FF + 0x0001, accepted at t → result 0x0100, carry_out=0, zero=0, negative=0, overflow=0; done only in cycle t+3.
2. SUB 0x1234 − 0x1234 → result 0x0000, zero=1, carry_out=1, ult=0, ule=1, slt=0, sle=1.
3. SUB 0x0001 − 0x0002 → result 0xFFFF, negative=1, ult=1, overflow=0, slt=1, lsb=1.
4. SUB 0x8000 − 0x0001 → result 0x7FFF, overflow=1, negative=0, slt=1, ult=0.
5. ADC 0xFFFF + 0x0000 with carry_in=1 → result 0x0000, carry_out=1, zero=1. Then a second start asserted in the DONE cycle → accepted, busy the next cycle.
6. A start pulsed during BYTE is ignored (one done only). Separately, reset asserted at byte 1 → the next cycle shows busy=0, done=0, result=0 and all flags 0.
